// File: rtl/breakout_pkg.sv
// Shared breakout playfield constants, FSM state encoding and index types.
// BRICK_SIDE_BOUNCE_EN (consumed by brick_collision_sched) selects side bounces.
package breakout_pkg;

  localparam int ROWS      = 5;
  localparam int COLS      = 12;
  localparam int GRID_X0   = 250;
  localparam int GRID_X1   = 790;
  localparam int GRID_Y0   = 35;
  localparam int BRICK_W   = 45;
  localparam int BRICK_H   = 25;
  localparam int BALL_HALF = 5;
  localparam int PAD_HW    = 25;
  localparam int PAD_HH    = 5;

  localparam int NBRICKS = ROWS * COLS;
  localparam int IDX_W   = $clog2(NBRICKS);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [10:0]      coord_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALLS,
    S_SCAN,
    S_REPORT
  } state_t;

endpackage

// File: rtl/brick_overlap.sv
// Ball-vs-box comparator; margins are folded onto the non-subtracting side.
// Upper y bound is optional so the paddle can test "at or below" only.
module brick_overlap
  import breakout_pkg::*;
#(
  parameter coord_t X_LO_M  = 11'd0,
  parameter coord_t X_HI_M  = 11'd0,
  parameter coord_t Y_LO_M  = 11'd0,
  parameter coord_t Y_HI_M  = 11'd0,
  parameter bit     Y_HI_EN = 1'b1
) (
  input  logic [10:0] ball_x,
  input  logic [10:0] ball_y,
  input  logic [10:0] edge_x,
  input  logic [10:0] edge_y,
  output logic        hit
);

  logic x_ok;
  logic y_lo_ok;
  logic y_hi_ok;

  always_comb begin
    x_ok    = (ball_x + X_LO_M >= edge_x)
           && (ball_x <= edge_x + X_HI_M);
    y_lo_ok = (ball_y + Y_LO_M >= edge_y);
    y_hi_ok = !Y_HI_EN || (ball_y <= edge_y + Y_HI_M);
    hit     = x_ok && y_lo_ok && y_hi_ok;
  end

endmodule

// File: rtl/brick_collision_sched.sv
// Per-tick collision scheduler: paddle/walls/ceiling, then a serial brick scan.
// Define BRICK_SIDE_BOUNCE_EN to report flip_x for hits on a brick's side.
module brick_collision_sched
  import breakout_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       clear_all,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_y,
  input  logic [2:0] rd_row,
  input  logic [3:0] rd_col,
  output logic       rd_hit,
  output logic       busy,
  output logic       result_valid,
  output logic       flip_x,
  output logic       flip_y,
  output logic       brick_hit,
  output logic [2:0] hit_row,
  output logic [3:0] hit_col,
  output logic [5:0] bricks_left,
  output logic       all_clear
);

  state_t             state;
  logic [NBRICKS-1:0] mask;
  logic [9:0]         bx, by, px, py;
  idx_t               k;
  logic [2:0]         row;
  logic [3:0]         col;
  coord_t             left, top;
  coord_t             bx11, by11;
  logic               pad_hit, brick_ovl;
  logic               side_wall, ceil_hit, brick_match;
  idx_t               rd_idx;

  assign bx11 = {1'b0, bx};
  assign by11 = {1'b0, by};

  brick_overlap #(
    .X_LO_M (coord_t'(BALL_HALF + PAD_HW)),
    .X_HI_M (coord_t'(PAD_HW + BALL_HALF)),
    .Y_LO_M (coord_t'(BALL_HALF + PAD_HH)),
    .Y_HI_M (11'd0),
    .Y_HI_EN(1'b0)
  ) u_pad (
    .ball_x(bx11),
    .ball_y(by11),
    .edge_x({1'b0, px}),
    .edge_y({1'b0, py}),
    .hit   (pad_hit)
  );

  brick_overlap #(
    .X_LO_M (coord_t'(BALL_HALF)),
    .X_HI_M (coord_t'(BRICK_W + BALL_HALF)),
    .Y_LO_M (coord_t'(BALL_HALF)),
    .Y_HI_M (coord_t'(BRICK_H + BALL_HALF)),
    .Y_HI_EN(1'b1)
  ) u_brick (
    .ball_x(bx11),
    .ball_y(by11),
    .edge_x(left),
    .edge_y(top),
    .hit   (brick_ovl)
  );

`ifdef BRICK_SIDE_BOUNCE_EN
  logic side_bounce;
  assign side_bounce = (bx11 < left)
                    || (bx11 > left + coord_t'(BRICK_W));
`endif

  assign side_wall   = (bx11 >= coord_t'(GRID_X1))
                    || (bx11 <= coord_t'(GRID_X0));
  assign ceil_hit    = (by11 <= coord_t'(GRID_Y0));
  assign brick_match = brick_ovl && !mask[k];

  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_REPORT);
  assign all_clear    = (bricks_left == 6'd0);

  assign rd_idx = idx_t'(rd_row) * idx_t'(COLS) + idx_t'(rd_col);
  assign rd_hit = (rd_row < 3'(ROWS)) && (rd_col < 4'(COLS))
                ? mask[rd_idx] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mask        <= '0;
      bricks_left <= 6'(NBRICKS);
      flip_x      <= 1'b0;
      flip_y      <= 1'b0;
      brick_hit   <= 1'b0;
      hit_row     <= '0;
      hit_col     <= '0;
      bx          <= '0;
      by          <= '0;
      px          <= '0;
      py          <= '0;
      k           <= '0;
      row         <= '0;
      col         <= '0;
      left        <= coord_t'(GRID_X0);
      top         <= coord_t'(GRID_Y0);
    end else if (clear_all) begin
      // Abort any in-flight tick; the pending result is dropped.
      state       <= S_IDLE;
      mask        <= '0;
      bricks_left <= 6'(NBRICKS);
    end else begin
      unique case (state)
        S_IDLE: begin
          if (tick) begin
            bx    <= ball_x;
            by    <= ball_y;
            px    <= paddle_x;
            py    <= paddle_y;
            state <= S_WALLS;
          end
        end
        S_WALLS: begin
          if (pad_hit) begin
            flip_x    <= 1'b0;
            flip_y    <= 1'b1;
            brick_hit <= 1'b0;
            state     <= S_REPORT;
          end else if (side_wall) begin
            flip_x    <= 1'b1;
            flip_y    <= 1'b0;
            brick_hit <= 1'b0;
            state     <= S_REPORT;
          end else if (ceil_hit) begin
            flip_x    <= 1'b0;
            flip_y    <= 1'b1;
            brick_hit <= 1'b0;
            state     <= S_REPORT;
          end else begin
            k     <= '0;
            row   <= '0;
            col   <= '0;
            left  <= coord_t'(GRID_X0);
            top   <= coord_t'(GRID_Y0);
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (brick_match) begin
            mask[k]     <= 1'b1;
            bricks_left <= bricks_left - 6'd1;
            hit_row     <= row;
            hit_col     <= col;
            brick_hit   <= 1'b1;
`ifdef BRICK_SIDE_BOUNCE_EN
            flip_x      <= side_bounce;
            flip_y      <= !side_bounce;
`else
            flip_x      <= 1'b0;
            flip_y      <= 1'b1;
`endif
            state       <= S_REPORT;
          end else if (k == idx_t'(NBRICKS - 1)) begin
            flip_x    <= 1'b0;
            flip_y    <= 1'b0;
            brick_hit <= 1'b0;
            state     <= S_REPORT;
          end else begin
            k <= k + idx_t'(1);
            if (col == 4'(COLS - 1)) begin
              col  <= '0;
              row  <= row + 3'd1;
              left <= coord_t'(GRID_X0);
              top  <= top + coord_t'(BRICK_H);
            end else begin
              col  <= col + 4'd1;
              left <= left + coord_t'(BRICK_W);
            end
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_collision_sched.sv
// Directed vector bench for brick_collision_sched.
// Honours BRICK_SIDE_BOUNCE_EN when computing brick-hit flip expectations.
module tb_brick_collision_sched;

`ifdef BRICK_SIDE_BOUNCE_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick, clear_all;
  logic [9:0] ball_x, ball_y, paddle_x, paddle_y;
  logic [2:0] rd_row;
  logic [3:0] rd_col;
  logic       rd_hit, busy, result_valid;
  logic       flip_x, flip_y, brick_hit;
  logic [2:0] hit_row;
  logic [3:0] hit_col;
  logic [5:0] bricks_left;
  logic       all_clear;

  brick_collision_sched dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .clear_all   (clear_all),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .paddle_x    (paddle_x),
    .paddle_y    (paddle_y),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_hit      (rd_hit),
    .busy        (busy),
    .result_valid(result_valid),
    .flip_x      (flip_x),
    .flip_y      (flip_y),
    .brick_hit   (brick_hit),
    .hit_row     (hit_row),
    .hit_col     (hit_col),
    .bricks_left (bricks_left),
    .all_clear   (all_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0] bx, by, px, py;
    int         cyc;
    bit         fx, fy, bh;
    int         row, col, left;
  } vec_t;

  vec_t v[10];

  int   r_cyc;
  logic r_fx, r_fy, r_bh, r_rd;
  logic [2:0] r_row;
  logic [3:0] r_col;
  logic [5:0] r_left;

  task automatic wait_result(input int start);
    r_cyc = start;
    while (!result_valid && r_cyc < 100) begin
      @(negedge clk);
      r_cyc++;
    end
    if (!result_valid) r_cyc = -1;
    r_fx   = flip_x;
    r_fy   = flip_y;
    r_bh   = brick_hit;
    r_row  = hit_row;
    r_col  = hit_col;
    r_left = bricks_left;
    r_rd   = rd_hit;
  endtask

  task automatic do_tick(input logic [9:0] bx, by, px, py);
    @(negedge clk);
    ball_x = bx; ball_y = by; paddle_x = px; paddle_y = py;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("busy_rise", busy, 1);
    wait_result(1);
    @(negedge clk);
    chk("busy_fall", busy, 0);
  endtask

  task automatic no_pulse(input string nm, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    chk(nm, seen, 0);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] r,
                        input logic [3:0] c, input logic e);
    rd_row = r; rd_col = c;
    #1;
    chk(nm, rd_hit, e);
  endtask

  initial begin
    v[0] = '{10'd480, 10'd200, 10'd450, 10'd500, 62, 0, 0, 0, 0, 0, 60};
    v[1] = '{10'd250, 10'd300, 10'd450, 10'd500, 2, 1, 0, 0, 0, 0, 60};
    v[2] = '{10'd480, 10'd35,  10'd450, 10'd500, 2, 0, 1, 0, 0, 0, 60};
    v[3] = '{10'd450, 10'd492, 10'd450, 10'd500, 2, 0, 1, 0, 0, 0, 60};
    v[4] = '{10'd250, 10'd495, 10'd260, 10'd500, 2, 0, 1, 0, 0, 0, 60};
    v[5] = '{10'd272, 10'd47,  10'd450, 10'd500, 3, 0, 1, 1, 0, 0, 59};
    v[6] = '{10'd272, 10'd47,  10'd450, 10'd500, 62, 0, 0, 0, 0, 0, 59};
    v[7] = '{10'd291, 10'd47,  10'd450, 10'd500, 4, SB, !SB, 1, 0, 1, 58};
    v[8] = '{10'd700, 10'd150, 10'd450, 10'd500, 60, 0, 1, 1, 4, 9, 57};
    v[9] = '{10'd700, 10'd150, 10'd450, 10'd500, 61, 0, 1, 1, 4, 10, 56};

    rst = 1'b1; tick = 1'b0; clear_all = 1'b0;
    ball_x = '0; ball_y = '0; paddle_x = '0; paddle_y = '0;
    rd_row = '0; rd_col = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", bricks_left, 60);
    chk("rst_allclr", all_clear, 0);
    chk("rst_flags", {flip_x, flip_y, brick_hit}, 0);
    chk("rst_hitpos", {hit_row, hit_col}, 0);
    chk("rst_rd", rd_hit, 0);

    for (int i = 0; i < 10; i++) begin
      rd_row = 3'd0; rd_col = 4'd0;
      do_tick(v[i].bx, v[i].by, v[i].px, v[i].py);
      chk($sformatf("v%0d_cyc", i), r_cyc, v[i].cyc);
      chk($sformatf("v%0d_fx", i), r_fx, v[i].fx);
      chk($sformatf("v%0d_fy", i), r_fy, v[i].fy);
      chk($sformatf("v%0d_bh", i), r_bh, v[i].bh);
      chk($sformatf("v%0d_left", i), r_left, v[i].left);
      if (v[i].bh) begin
        chk($sformatf("v%0d_row", i), r_row, v[i].row);
        chk($sformatf("v%0d_col", i), r_col, v[i].col);
      end
      if (i == 5) chk("v5_rd_in_report", r_rd, 1);
    end

    rd_chk("rd_0_0", 3'd0, 4'd0, 1'b1);
    rd_chk("rd_0_1", 3'd0, 4'd1, 1'b1);
    rd_chk("rd_4_9", 3'd4, 4'd9, 1'b1);
    rd_chk("rd_4_10", 3'd4, 4'd10, 1'b1);
    rd_chk("rd_1_0", 3'd1, 4'd0, 1'b0);
    rd_chk("rd_4_11", 3'd4, 4'd11, 1'b0);
    rd_chk("rd_row_oor", 3'd5, 4'd0, 1'b0);
    rd_chk("rd_col_oor", 3'd0, 4'd12, 1'b0);

    // Tick while busy is dropped: first tick still ends at 62, no second.
    @(negedge clk);
    ball_x = 10'd480; ball_y = 10'd200; paddle_x = 10'd450;
    paddle_y = 10'd500; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    ball_x = 10'd250; ball_y = 10'd300; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_result(5);
    chk("drop_cyc", r_cyc, 62);
    chk("drop_fx", r_fx, 0);
    chk("drop_flags", {r_fy, r_bh}, 0);
    no_pulse("drop_no_second", 10);

    // clear_all in the middle of SCAN.
    @(negedge clk);
    ball_x = 10'd480; ball_y = 10'd200; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (9) @(negedge clk);
    chk("clr_busy_pre", busy, 1);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_left", bricks_left, 60);
    rd_chk("clr_rd_0_0", 3'd0, 4'd0, 1'b0);
    no_pulse("clr_no_pulse", 70);

    // clear_all wins over tick in the same cycle.
    @(negedge clk);
    tick = 1'b1; clear_all = 1'b1;
    @(negedge clk);
    tick = 1'b0; clear_all = 1'b0;
    chk("clr_tick_busy", busy, 0);
    no_pulse("clr_tick_no_pulse", 5);

    // Hit a brick, then reset in the middle of a scan.
    do_tick(10'd272, 10'd47, 10'd450, 10'd500);
    chk("pre_rst_left", r_left, 59);
    chk("pre_rst_bh", r_bh, 1);
    @(negedge clk);
    ball_x = 10'd480; ball_y = 10'd200; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_left", bricks_left, 60);
    chk("mrst_flags", {flip_x, flip_y, brick_hit}, 0);
    rd_chk("mrst_rd_0_0", 3'd0, 4'd0, 1'b0);
    no_pulse("mrst_no_pulse", 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
